ysyx_23060191_if_id_buffer: RTL and testbench

IF→ID decoupling buffer: a 2-entry FIFO with valid/ready handshakes on both sides.
- Holds fetched {pc, inst} pairs between the fetch stage and the decode stage.
- Removes the combinational ready path from decode back into fetch.
- Discards wrong-path instructions when a jump redirect (flush) is raised by the execute stage.

---
 rtl/ysyx_23060191_if_id_buffer_pkg.sv | 11 +
 rtl/ysyx_23060191_if_id_buffer.sv | 73 +++++++
 tb/tb_ysyx_23060191_if_id_buffer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ysyx_23060191_if_id_buffer_pkg.sv
// Constants shared between the IF/ID buffer and the decode stage.
package ysyx_23060191_if_id_buffer_pkg;

  localparam int CPU_WIDTH  = 32;
  localparam int IFID_DEPTH = 2;

  // Occupancy encoding used by the buffer's count output.
  localparam logic [1:0] IFID_EMPTY = 2'd0;
  localparam logic [1:0] IFID_FULL  = 2'(IFID_DEPTH);

endpackage

// File: rtl/ysyx_23060191_if_id_buffer.sv
// IF->ID decoupling buffer: 2-entry {pc, inst} FIFO with valid/ready on both
// sides. A jump redirect (flush) discards every held and incoming entry.
module ysyx_23060191_if_id_buffer #(
  parameter int CPU_WIDTH = ysyx_23060191_if_id_buffer_pkg::CPU_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CPU_WIDTH-1:0] in_pc,
  input  logic [CPU_WIDTH-1:0] in_inst,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CPU_WIDTH-1:0] out_pc,
  output logic [CPU_WIDTH-1:0] out_inst,
  output logic [1:0]           count
);

  import ysyx_23060191_if_id_buffer_pkg::*;

  logic [CPU_WIDTH-1:0] r_pc   [IFID_DEPTH];
  logic [CPU_WIDTH-1:0] r_inst [IFID_DEPTH];
  logic                 r_wp;
  logic                 r_rp;
  logic [1:0]           r_count;

  logic w_push;
  logic w_pop;

  // in_ready comes only from registered state, so fetch never sees a
  // combinational path from decode's out_ready.
  assign in_ready  = (r_count != IFID_FULL);
  assign out_valid = (r_count != IFID_EMPTY) & ~flush;
  assign out_pc    = r_pc[r_rp];
  assign out_inst  = r_inst[r_rp];
  assign count     = r_count;

  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = out_valid & out_ready;

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_count <= IFID_EMPTY;
      // NOTE: the storage array is reset too, so out_pc/out_inst read as
      // zero after reset instead of leaking stale or X data to decode.
      for (int i = 0; i < IFID_DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_inst[i] <= '0;
      end
    end else if (flush) begin
      // Contents are kept; only the bookkeeping is cleared.
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_count <= IFID_EMPTY;
    end else begin
      if (w_push) begin
        r_pc[r_wp]   <= in_pc;
        r_inst[r_wp] <= in_inst;
        r_wp         <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_ysyx_23060191_if_id_buffer.sv
// Self-checking bench for the IF/ID buffer against a queue-based model.
module tb_ysyx_23060191_if_id_buffer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [1:0]  count;

  int checks   = 0;
  int failures = 0;

  ent_t model_q[$];

  ysyx_23060191_if_id_buffer #(.CPU_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Two reset cycles with in_valid high, then check the post-reset state.
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_pc = 32'hdead_beef; in_inst = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_q.delete();
    rst = 1'b0; in_valid = 1'b0;
    #3;
    check("rst_count",     32'(count),     32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_pc",    out_pc,         32'd0);
    check("rst_out_inst",  out_inst,       32'd0);
    @(posedge clk); #1;
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic fl, input logic ordy);
    logic exp_ready, exp_valid, push, pop;
    in_valid = v; in_pc = pc; in_inst = inst; flush = fl; out_ready = ordy;
    #3;
    exp_ready = (model_q.size() < 2);
    exp_valid = (model_q.size() > 0) && !fl;
    check("in_ready",  32'(in_ready),  32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("count",     32'(count),     32'(model_q.size()));
    if (exp_valid) begin
      check("out_pc",   out_pc,   model_q[0].pc);
      check("out_inst", out_inst, model_q[0].inst);
    end
    push = v && exp_ready && !fl;
    pop  = exp_valid && ordy;
    @(posedge clk); #1;
    if (fl) model_q.delete();
    else begin
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back('{pc: pc, inst: inst});
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    @(posedge clk); #1;

    do_reset();

    // Single pass
    cycle(1'b1, 32'h8000_0000, 32'h0000_0413, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Fill and backpressure; third entry waits until a slot frees
    cycle(1'b1, 32'h8000_0000, 32'hA000_0000, 1'b0, 1'b0);
    cycle(1'b1, 32'h8000_0004, 32'hA000_0004, 1'b0, 1'b0);
    cycle(1'b1, 32'h8000_0008, 32'hA000_0008, 1'b0, 1'b0);
    cycle(1'b1, 32'h8000_0008, 32'hA000_0008, 1'b0, 1'b1);
    cycle(1'b1, 32'h8000_0008, 32'hA000_0008, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Streaming across pointer wrap
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 32'h8000_0000 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Flush while full with a concurrent push and out_ready
    cycle(1'b1, 32'h8000_0000, 32'hC000_0000, 1'b0, 1'b0);
    cycle(1'b1, 32'h8000_0004, 32'hC000_0004, 1'b0, 1'b0);
    cycle(1'b1, 32'h8000_0008, 32'hC000_0008, 1'b1, 1'b1);
    cycle(1'b1, 32'h8000_0100, 32'hC000_0100, 1'b0, 1'b0);
    cycle(1'b1, 32'h8000_0104, 32'hC000_0104, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Push and pop together at count=1
    cycle(1'b1, 32'h8000_0200, 32'hD000_0200, 1'b0, 1'b1);
    cycle(1'b1, 32'h8000_0204, 32'hD000_0204, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Mid-operation reset, then randomized traffic with flushes and resets
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
    end

    // Flush and reset together behave as reset
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
